// File: rtl/uart_rx_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// uart_rx_cmd_ctrl
// Command parser sitting behind the UART receiver. Decodes write frames
// (0xAA, ADDR, DATA) into a register-file write strobe and read frames
// (0xBB, ADDR) into a register-file read whose returned byte is forwarded to
// the UART transmitter through a valid/busy handshake.
//
// Ports:
//   SysCtrl_CLK / SysCtrl_RST      clock, async active-high reset
//   SysCtrl_RX_P_DATA / _RX_D_VLD  received byte + one-cycle valid pulse
//   SysCtrl_RdData / _RdData_Valid register-file read data + qualifier
//   SysCtrl_TX_Busy                transmitter cannot accept a byte
//   SysCtrl_Address                register-file address (held)
//   SysCtrl_WrEn / SysCtrl_WrData  one-cycle write strobe + write data (held)
//   SysCtrl_RdEn                   one-cycle read strobe
//   SysCtrl_TX_P_DATA / _TX_D_VLD  byte offered to transmitter, held until taken
//   SysCtrl_Err                    one-cycle error pulse
// ----------------------------------------------------------------------------
module uart_rx_cmd_ctrl #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  SysCtrl_CLK,
   input  logic                  SysCtrl_RST,
   input  logic [7:0]            SysCtrl_RX_P_DATA,
   input  logic                  SysCtrl_RX_D_VLD,
   input  logic [7:0]            SysCtrl_RdData,
   input  logic                  SysCtrl_RdData_Valid,
   input  logic                  SysCtrl_TX_Busy,
   output logic [ADDR_WIDTH-1:0] SysCtrl_Address,
   output logic                  SysCtrl_WrEn,
   output logic [7:0]            SysCtrl_WrData,
   output logic                  SysCtrl_RdEn,
   output logic [7:0]            SysCtrl_TX_P_DATA,
   output logic                  SysCtrl_TX_D_VLD,
   output logic                  SysCtrl_Err
);

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 8;

   localparam logic [DATA_W-1:0] CMD_WR  = 8'hAA;
   localparam logic [DATA_W-1:0] CMD_RD  = 8'hBB;
   localparam logic [CNT_W-1:0]  TMO_VAL = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_ADDR = 3'd1,
      S_WR_DATA = 3'd2,
      S_RD_ADDR = 3'd3,
      S_RD_WAIT = 3'd4,
      S_TX_SEND = 3'd5
   } state_e;

   state_e                  state_q,   state_d;
   logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
   logic [DATA_W-1:0]       wr_data_q, wr_data_d;
   logic                    wr_en_q,   wr_en_d;
   logic                    rd_en_q,   rd_en_d;
   logic [DATA_W-1:0]       tx_data_q, tx_data_d;
   logic                    tx_vld_q,  tx_vld_d;
   logic                    err_q,     err_d;
   logic [CNT_W-1:0]        cnt_q,     cnt_d;

   // State and output registers
   always_ff @(posedge SysCtrl_CLK or posedge SysCtrl_RST) begin
      if (SysCtrl_RST) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         tx_data_q <= '0;
         tx_vld_q  <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wr_data_q <= wr_data_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         tx_data_q <= tx_data_d;
         tx_vld_q  <= tx_vld_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      tx_data_d = tx_data_q;
      tx_vld_d  = tx_vld_q;
      err_d     = 1'b0;
      cnt_d     = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (SysCtrl_RX_D_VLD) begin
               if (SysCtrl_RX_P_DATA == CMD_WR) begin
                  state_d = S_WR_ADDR;
               end else if (SysCtrl_RX_P_DATA == CMD_RD) begin
                  state_d = S_RD_ADDR;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         S_WR_ADDR: begin
            if (SysCtrl_RX_D_VLD) begin
               addr_d  = SysCtrl_RX_P_DATA[ADDR_WIDTH-1:0];
               state_d = S_WR_DATA;
            end
         end

         S_WR_DATA: begin
            if (SysCtrl_RX_D_VLD) begin
               wr_data_d = SysCtrl_RX_P_DATA;
               wr_en_d   = 1'b1;
               state_d   = S_IDLE;
            end
         end

         S_RD_ADDR: begin
            if (SysCtrl_RX_D_VLD) begin
               addr_d  = SysCtrl_RX_P_DATA[ADDR_WIDTH-1:0];
               rd_en_d = 1'b1;
               cnt_d   = '0;
               state_d = S_RD_WAIT;
            end
         end

         S_RD_WAIT: begin
            // cnt_d counts RD_WAIT cycles completed; data beats the timeout
            cnt_d = cnt_q + CNT_W'(1);
            if (SysCtrl_RdData_Valid) begin
               tx_data_d = SysCtrl_RdData;
               tx_vld_d  = 1'b1;
               state_d   = S_TX_SEND;
            end else if (cnt_d == TMO_VAL) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
            // A stray RX byte is dropped; merges with a timeout into one pulse
            if (SysCtrl_RX_D_VLD) begin
               err_d = 1'b1;
            end
         end

         S_TX_SEND: begin
            if (!SysCtrl_TX_Busy) begin
               tx_vld_d = 1'b0;
               state_d  = S_IDLE;
            end
            if (SysCtrl_RX_D_VLD) begin
               err_d = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign SysCtrl_Address   = addr_q;
   assign SysCtrl_WrEn      = wr_en_q;
   assign SysCtrl_WrData    = wr_data_q;
   assign SysCtrl_RdEn      = rd_en_q;
   assign SysCtrl_TX_P_DATA = tx_data_q;
   assign SysCtrl_TX_D_VLD  = tx_vld_q;
   assign SysCtrl_Err       = err_q;

endmodule

// File: doc/uart_rx_cmd_ctrl.md
# uart_rx_cmd_ctrl

Command controller directly downstream of the UART receiver. It consumes the receiver's parallel byte output (8-bit data plus a one-cycle valid pulse) and parses write and read command frames. Write frames produce a register-file write strobe. Read frames issue a register-file read, then hand the returned byte to the UART transmitter through a valid/busy handshake.

## Interface
Parameters:
- ADDR_WIDTH, default 4: register-file address width, taken from the low bits of the address byte.
- TIMEOUT, default 255: maximum number of cycles to wait for read data; legal range 1..255; 8-bit counter.

Ports:
- SysCtrl_CLK  input  1  sole clock; all state changes on its rising edge.
- SysCtrl_RST  input  1  reset, asynchronous, active-high.
- SysCtrl_RX_P_DATA  input  8  received byte from the UART receiver.
- SysCtrl_RX_D_VLD  input  1  one-cycle pulse; RX_P_DATA is valid in that cycle.
- SysCtrl_RdData  input  8  register-file read data.
- SysCtrl_RdData_Valid  input  1  one-cycle pulse qualifying RdData.
- SysCtrl_TX_Busy  input  1  transmitter busy; a byte cannot be accepted while high.
- SysCtrl_Address  output  ADDR_WIDTH  register-file address.
- SysCtrl_WrEn  output  1  one-cycle write strobe.
- SysCtrl_WrData  output  8  write data.
- SysCtrl_RdEn  output  1  one-cycle read strobe.
- SysCtrl_TX_P_DATA  output  8  byte offered to the transmitter.
- SysCtrl_TX_D_VLD  output  1  TX byte valid; held until accepted.
- SysCtrl_Err  output  1  one-cycle error pulse.

## Operation
- Command bytes: 0xAA = write frame (CMD, ADDR, DATA); 0xBB = read frame (CMD, ADDR).
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE:
  - byte 0xAA -> WR_ADDR; byte 0xBB -> RD_ADDR.
  - any other byte -> stays IDLE, Err pulses.
- WR_ADDR: byte -> Address <= byte[ADDR_WIDTH-1:0]; upper bits are ignored. Next state WR_DATA.
- WR_DATA: byte -> WrData <= byte; WrEn pulses; next state IDLE.
- RD_ADDR: byte -> Address latched; RdEn pulses; timeout counter cleared; next state RD_WAIT.
- RD_WAIT:
  - RdData_Valid -> TX_P_DATA <= RdData; next state TX_SEND.
  - Counter reaches TIMEOUT without RdData_Valid -> Err pulses; next state IDLE.
- TX_SEND: TX_D_VLD is high; the transfer completes on the first edge where TX_D_VLD=1 and TX_Busy=0; next state IDLE.
- RX_D_VLD arriving in RD_WAIT or TX_SEND: the byte is dropped, Err pulses, and the state is unchanged.
- Address and WrData hold their last latched values until overwritten. TX_P_DATA holds its value after the transfer.
- Simultaneous events:
  - In RD_WAIT, RdData_Valid and the timeout in the same cycle: data wins, no Err.
  - A dropped RX byte plus a timeout in the same cycle: a single Err pulse.

## Timing
- Reset: all outputs are 0, state is IDLE, timeout counter is 0. Reset asserted mid-frame aborts the frame, and no strobe is produced.
- WrEn is registered: it is high in the cycle after the edge that samples the DATA byte's RX_D_VLD, for exactly 1 cycle. Address and WrData are already stable in that cycle.
- RdEn: high for 1 cycle, in the cycle after the ADDR byte's RX_D_VLD edge. Address is stable in that same cycle.
- Timeout count: starts in the first RD_WAIT cycle (the cycle in which RdEn is high) and increments every RD_WAIT cycle. Err fires on the edge where the count equals TIMEOUT.
- RdData_Valid is accepted in any RD_WAIT cycle, including the RdEn cycle itself.
- TX_D_VLD rises in the cycle after RdData_Valid is captured. It falls in the cycle after acceptance, so minimum latency from RdData_Valid to TX_D_VLD is 1 cycle.
- Err: 1-cycle pulse, registered, high in the cycle after the causing edge.
- There is no inter-byte timeout in the WR_* and RD_ADDR states; the frame waits indefinitely for its next byte.

## Test plan
- Write frame 0xAA, 0x05, 0x3C, each byte a 1-cycle RX_D_VLD -> exactly one WrEn cycle with Address=5 and WrData=0x3C; RdEn, Err and TX_D_VLD stay 0.
- Read frame 0xBB, 0x03; RdData=0x7E with RdData_Valid 2 cycles after RdEn; TX_Busy=0 -> RdEn 1 cycle with Address=3; TX_D_VLD high 1 cycle with TX_P_DATA=0x7E; state returns to IDLE.
- Read with TX_Busy held high 10 cycles after data returns -> TX_D_VLD stays high with 0x7E stable for 10 cycles and drops the cycle after Busy falls.
- Read with no RdData_Valid and TIMEOUT=4 -> Err pulses once; next frame 0xAA, 0x01, 0x11 writes normally.
- Unknown byte 0x55 in IDLE -> Err pulse, no strobes. An RX byte injected during RD_WAIT -> Err pulse, and the read still completes.
- Reset asserted between ADDR and DATA of a write frame -> all outputs go to 0 immediately, no WrEn. After release, a fresh frame works.
